imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/loader_pkg.sv | 38 +++
 rtl/byte_packer.sv | 48 ++++
 rtl/imem_loader.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared types and widths for the IMem boot loader.
// LOADER_CHECKSUM_EN adds the trailing checksum state.
package loader_pkg;

    localparam int BYTE_W = 8;
    localparam int HDR_W  = 16;
    localparam int WORD_W = 32;
    localparam int LANES  = WORD_W / BYTE_W;
    localparam int LANE_W = $clog2(LANES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_DATA,
`ifdef LOADER_CHECKSUM_EN
        ST_CHK,
`endif
        ST_DONE,
        ST_ERR
    } state_t;

    // State entered once the payload (possibly empty) has been consumed.
`ifdef LOADER_CHECKSUM_EN
    localparam state_t ST_POST_DATA = ST_CHK;
`else
    localparam state_t ST_POST_DATA = ST_DONE;
`endif

    function automatic logic is_busy(input state_t s);
`ifdef LOADER_CHECKSUM_EN
        return s inside {ST_HDR0, ST_HDR1, ST_DATA, ST_CHK};
`else
        return s inside {ST_HDR0, ST_HDR1, ST_DATA};
`endif
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Big-endian byte-to-word assembler; emits a one-cycle IMem write per word.
module byte_packer
    import loader_pkg::*;
#(
    parameter logic [WORD_W-1:0] ADDR_BASE = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              byte_en_i,
    input  logic [LANE_W-1:0] lane_i,
    input  logic [BYTE_W-1:0] byte_i,
    input  logic [HDR_W-1:0]  word_idx_i,
    output logic              we_o,
    output logic [WORD_W-1:0] addr_o,
    output logic [WORD_W-1:0] wdata_o
);

    logic [WORD_W-BYTE_W-1:0] acc_q;
    logic                     we_q;
    logic [WORD_W-1:0]        addr_q;
    logic [WORD_W-1:0]        wdata_q;

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= ADDR_BASE;
            wdata_q <= '0;
        end else begin
            we_q <= 1'b0;
            if (byte_en_i) begin
                acc_q <= {acc_q[WORD_W-2*BYTE_W-1:0], byte_i};
                // addr/wdata only move on a completed word, so they hold otherwise.
                if (lane_i == LANE_W'(LANES - 1)) begin
                    we_q    <= 1'b1;
                    wdata_q <= {acc_q, byte_i};
                    addr_q  <= ADDR_BASE + {14'd0, word_idx_i, 2'b00};
                end
            end
        end
    end

    assign we_o    = we_q;
    assign addr_o  = addr_q;
    assign wdata_o = wdata_q;

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed byte image into IMem, then releases the CPU reset.
// LOADER_CHECKSUM_EN appends an 8-bit zero-sum checksum byte to the stream.
module imem_loader
    import loader_pkg::*;
#(
    parameter logic [WORD_W-1:0] ADDR_BASE   = 32'h0000_0000,
    parameter int                DEPTH_WORDS = 256
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [WORD_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [HDR_W:0] DEPTH_L = (HDR_W + 1)'(DEPTH_WORDS);

    state_t            state_q, state_d;
    logic [BYTE_W-1:0] hdr_hi_q;
    logic [HDR_W-1:0]  n_q;
    logic [HDR_W-1:0]  word_idx_q;
    logic [LANE_W-1:0] lane_q;
    logic              in_ready_q, busy_q, done_q, error_q, cpu_rst_n_q;

    logic              fire, restart, word_end, last_byte;
    logic [HDR_W-1:0]  n_hdr;

    assign fire      = in_valid && in_ready_q;
    assign restart   = start && (state_q inside {ST_IDLE, ST_DONE, ST_ERR});
    assign n_hdr     = {hdr_hi_q, in_data};
    assign word_end  = (lane_q == LANE_W'(LANES - 1));
    assign last_byte = word_end && (word_idx_q == n_q - HDR_W'(1));

`ifdef LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] sum_q;
    logic [BYTE_W-1:0] chk_total;
    assign chk_total = sum_q + in_data;
`endif

    // NOTE: default first so every path assigns state_d and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: if (start) state_d = ST_HDR0;
            ST_HDR0: if (fire) state_d = ST_HDR1;
            ST_HDR1: begin
                if (fire) begin
                    if ({1'b0, n_hdr} > DEPTH_L) state_d = ST_ERR;
                    else if (n_hdr == '0)        state_d = ST_POST_DATA;
                    else                         state_d = ST_DATA;
                end
            end
            ST_DATA: if (fire && last_byte) state_d = ST_POST_DATA;
`ifdef LOADER_CHECKSUM_EN
            ST_CHK: if (fire) state_d = (chk_total == '0) ? ST_DONE : ST_ERR;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Status outputs are decoded from state_d so they line up with state_q.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            hdr_hi_q    <= '0;
            n_q         <= '0;
            word_idx_q  <= '0;
            lane_q      <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cpu_rst_n_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            in_ready_q  <= is_busy(state_d);
            busy_q      <= is_busy(state_d);
            done_q      <= (state_d == ST_DONE);
            error_q     <= (state_d == ST_ERR);
            cpu_rst_n_q <= (state_d == ST_DONE);

            if (restart) begin
                n_q        <= '0;
                word_idx_q <= '0;
                lane_q     <= '0;
`ifdef LOADER_CHECKSUM_EN
                sum_q      <= '0;
`endif
            end

            if (fire) begin
                case (state_q)
                    ST_HDR0: hdr_hi_q <= in_data;
                    ST_HDR1: n_q      <= n_hdr;
                    ST_DATA: begin
                        lane_q <= lane_q + LANE_W'(1);
                        // Index parks at N-1 on the final word instead of wrapping.
                        if (word_end && !last_byte) word_idx_q <= word_idx_q + HDR_W'(1);
`ifdef LOADER_CHECKSUM_EN
                        sum_q <= sum_q + in_data;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    byte_packer #(
        .ADDR_BASE (ADDR_BASE)
    ) u_packer (
        .clk        (CLK),
        .rst        (rst),
        .byte_en_i  (fire && (state_q == ST_DATA)),
        .lane_i     (lane_q),
        .byte_i     (in_data),
        .word_idx_i (word_idx_q),
        .we_o       (imem_we),
        .addr_o     (imem_addr),
        .wdata_o    (imem_wdata)
    );

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign cpu_rst_n = cpu_rst_n_q;

endmodule
